// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Multi-cycle RISC-V M-extension unit for the EX stage. A radix-2 shift-add
// multiplier and a restoring divider share one datapath (hi/lo/operand
// registers) and one iteration counter. Iteration runs on operand magnitudes;
// signs are applied when the result register is loaded.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      operation request, accepted only in IDLE when flush is low
//   flush      abort and discard the current operation
//   funct3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a       rs1 (multiplicand / dividend)
//   op_b       rs2 (multiplier / divisor)
//   rd_in      destination register, captured with the operands
//   busy       high in CALC and DONE
//   stall_out  combinational hold request for IF/ID/EX
//   done       one-cycle pulse; result and rd_out valid in that cycle
//   result     registered result, held until the next completion
//   rd_out     registered destination register
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; accepted start loads operands
// CALC  | one multiply/divide bit per cycle, XLEN cycles
// DONE  | done pulse; pipeline advances and captures result/rd_out

module ex_muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            stall_out,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   hi;        // mul: running high half / div: partial remainder
  logic [XLEN-1:0]   lo;        // mul: multiplier bits / div: dividend -> quotient
  logic [XLEN-1:0]   opnd;      // mul: |multiplicand| / div: |divisor|
  logic              is_div;
  logic              sel_hi;
  logic              is_rem;
  logic              neg_prod;
  logic              neg_quo;
  logic              neg_rem;
  logic              special;
  logic [XLEN-1:0]   spec_val;
  logic [4:0]        rd_hold;

  // Decode of the request presented in IDLE
  logic              is_div_in;
  logic              a_signed_in;
  logic              b_signed_in;
  logic              neg_a_in;
  logic              neg_b_in;
  logic [XLEN-1:0]   mag_a_in;
  logic [XLEN-1:0]   mag_b_in;
  logic              div_zero_in;
  logic              ovf_in;
  logic              special_in;
  logic [XLEN-1:0]   spec_val_in;

  always_comb begin
    is_div_in   = funct3[2];
    a_signed_in = is_div_in ? ~funct3[0] : (funct3 != 3'b011);
    b_signed_in = is_div_in ? ~funct3[0] : ~funct3[1];
    neg_a_in    = a_signed_in & op_a[XLEN-1];
    neg_b_in    = b_signed_in & op_b[XLEN-1];
    mag_a_in    = neg_a_in ? ('0 - op_a) : op_a;
    mag_b_in    = neg_b_in ? ('0 - op_b) : op_b;
    div_zero_in = is_div_in & (op_b == '0);
    ovf_in      = is_div_in & ~funct3[0] & (op_a == MIN_INT) & (op_b == '1);
    special_in  = div_zero_in | ovf_in;
    if (div_zero_in)
      spec_val_in = funct3[1] ? op_a : '1;
    else
      spec_val_in = funct3[1] ? '0 : op_a;
  end

  // One iteration step of the shared datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   hi_nxt;
  logic [XLEN-1:0]   lo_nxt;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // The true difference is below the divisor whenever it is used, so the
    // truncated subtraction is exact.
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (is_div) begin
      hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Result assembly from the final step's values
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_val;

  always_comb begin
    prod_fix = neg_prod ? ('0 - {hi_nxt, lo_nxt}) : {hi_nxt, lo_nxt};
    quo_fix  = neg_quo ? ('0 - lo_nxt) : lo_nxt;
    rem_fix  = neg_rem ? ('0 - hi_nxt) : hi_nxt;
    if (special)
      final_val = spec_val;
    else if (is_div)
      final_val = is_rem ? rem_fix : quo_fix;
    else
      final_val = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  assign stall_out = (state == S_CALC) | ((state == S_IDLE) & start & ~flush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      sel_hi   <= 1'b0;
      is_rem   <= 1'b0;
      neg_prod <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      special  <= 1'b0;
      spec_val <= '0;
      rd_hold  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !flush) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= is_div_in ? mag_a_in : mag_b_in;
            opnd     <= is_div_in ? mag_b_in : mag_a_in;
            is_div   <= is_div_in;
            sel_hi   <= (funct3[1:0] != 2'b00);
            is_rem   <= funct3[1];
            neg_prod <= neg_a_in ^ neg_b_in;
            neg_quo  <= neg_a_in ^ neg_b_in;
            neg_rem  <= neg_a_in;
            special  <= special_in;
            spec_val <= spec_val_in;
            rd_hold  <= rd_in;
            busy     <= 1'b1;
            if (FAST_SPECIAL && special_in) begin
              result <= spec_val_in;
              rd_out <= rd_in;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
            // Exit is tested before the increment, so cnt never wraps.
            if (cnt == CNT_LAST) begin
              result <= final_val;
              rd_out <= rd_hold;
              done   <= 1'b1;
              cnt    <= '0;
              state  <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_DONE: begin
          // done was committed on entry; flush here only confirms the return.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. Two instances share inputs: one with
// the fast special-case path and one without, so every operation checks both.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;

  logic        busy_f, stall_f, done_f;
  logic [31:0] result_f;
  logic [4:0]  rd_out_f;
  logic        busy_s, stall_s, done_s;
  logic [31:0] result_s;
  logic [4:0]  rd_out_s;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_exp;
  logic [4:0]  last_rd;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy_f), .stall_out(stall_f), .done(done_f),
    .result(result_f), .rd_out(rd_out_f)
  );

  ex_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy_s), .stall_out(stall_s), .done(done_s),
    .result(result_s), .rd_out(rd_out_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    sa = {{32{a[31]}}, a};
    ua = {32'b0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Called at a falling edge (cycle 0). Presents one request and watches both
  // instances for 40 cycles.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat_f = -1, lat_s = -1, nd_f = 0, nd_s = 0, st_f = 0, st_s = 0;
    logic [31:0] r_f = '0, r_s = '0;
    logic [4:0]  d_f = '0, d_s = '0;
    bit sp;
    sp = is_special(f, a, b);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    #1;
    chk({tag, "/stall_c0"}, {stall_f, stall_s}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (done_f) begin nd_f++; lat_f = c; r_f = result_f; d_f = rd_out_f; end
      if (done_s) begin nd_s++; lat_s = c; r_s = result_s; d_s = rd_out_s; end
      if (stall_f) st_f++;
      if (stall_s) st_s++;
      @(negedge clk);
    end
    chk({tag, "/res_fast"}, r_f, exp);
    chk({tag, "/res_slow"}, r_s, exp);
    chk({tag, "/rd_fast"}, d_f, rd);
    chk({tag, "/rd_slow"}, d_s, rd);
    chk({tag, "/lat_fast"}, lat_f, sp ? 1 : 33);
    chk({tag, "/lat_slow"}, lat_s, 33);
    chk({tag, "/ndone"}, {nd_f[7:0], nd_s[7:0]}, 16'h0101);
    chk({tag, "/stall_fast"}, st_f, sp ? 0 : 32);
    chk({tag, "/stall_slow"}, st_s, 32);
    chk({tag, "/held"}, {result_f, result_s}, {exp, exp});
    last_exp = exp;
    last_rd  = rd;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    logic [2:0]  f;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

    @(negedge clk);
    chk("reset/busy_done", {busy_f, busy_s, done_f, done_s}, 4'b0);
    chk("reset/result", {result_f, result_s}, 64'd0);
    chk("reset/rd_stall", {rd_out_f, rd_out_s, stall_f, stall_s}, 12'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul",      3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
    run_op("mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000);
    run_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF);
    run_op("div",      3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD);
    run_op("rem",      3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF);
    run_op("divu",     3'd5, 32'd7,         32'd2,         5'd9,  32'd3);
    run_op("remu",     3'd7, 32'd7,         32'd2,         5'd10, 32'd1);
    run_op("div_by0",  3'd4, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF);
    run_op("rem_by0",  3'd6, 32'd5,         32'd0,         5'd12, 32'd5);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);
    run_op("divu_by0", 3'd5, 32'd9,         32'd0,         5'd15, 32'hFFFF_FFFF);

    // Flush mid-operation, with an ignored start in CALC.
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd20; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      seen  = seen | done_f | done_s;
      start = (c == 5);
      if (c == 5) begin op_a = 32'd3; op_b = 32'd3; funct3 = 3'd0; rd_in = 5'd21; end
      flush = (c == 10);
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0;
    seen = seen | done_f | done_s;
    chk("flush/busy", {busy_f, busy_s}, 2'b00);
    chk("flush/no_done", seen, 1'b0);
    chk("flush/result", {result_f, result_s}, {last_exp, last_exp});
    chk("flush/rd", {rd_out_f, rd_out_s}, {last_rd, last_rd});
    run_op("after_flush", 3'd5, 32'd100, 32'd7, 5'd22, 32'd14);

    // Asynchronous reset between edges in the middle of CALC.
    funct3 = 3'd0; op_a = 32'h1234; op_b = 32'h10; rd_in = 5'd23; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 15; c++) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst/busy_done", {busy_f, busy_s, done_f, done_s}, 4'b0);
    chk("async_rst/result", {result_f, result_s}, 64'd0);
    chk("async_rst/rd", {rd_out_f, rd_out_s}, 10'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd24, 32'd12);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, 5'($urandom_range(0, 31)), model(f, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
